// File: rtl/picoblaze_io_bridge.sv
// picoblaze_io_bridge: KCPSM6 port-mapped I/O bridge with synchronised
// inputs, output registers, change-event flags and an acked interrupt.
//
// Ports:
//   clk_i, reset        clock, asynchronous active-high reset
//   port_id, out_port   kcpsm6 address / write data
//   write_strobe        OUTPUT qualifier (full 8-bit decode)
//   k_write_strobe      OUTPUTK qualifier (decodes port_id[3:0])
//   read_strobe         INPUT qualifier (clears flags on STAT_ADDR)
//   in_port             registered read data, 1-cycle latency
//   interrupt, interrupt_ack  request / acknowledge handshake
//   gpio_in             IN_CH x 8 asynchronous inputs
//   gpio_out            OUT_CH x 8 output registers
//
// Build option: define IO_READBACK_EN to let OUT_BASE+j read back
// gpio_out[j]; otherwise those addresses read 8'h00.

module picoblaze_io_bridge #(
  parameter int         IN_CH     = 2,
  parameter int         OUT_CH    = 3,
  parameter logic [7:0] IN_BASE   = 8'h00,
  parameter logic [7:0] OUT_BASE  = 8'h04,
  parameter logic [7:0] STAT_ADDR = 8'h10,
  parameter logic [7:0] MASK_ADDR = 8'h11
) (
  input  logic                clk_i,
  input  logic                reset,
  input  logic [7:0]          port_id,
  input  logic [7:0]          out_port,
  input  logic                write_strobe,
  input  logic                k_write_strobe,
  input  logic                read_strobe,
  output logic [7:0]          in_port,
  output logic                interrupt,
  input  logic                interrupt_ack,
  input  logic [IN_CH*8-1:0]  gpio_in,
  output logic [OUT_CH*8-1:0] gpio_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } irq_state_e;

  irq_state_e state_q, state_d;

  logic [IN_CH*8-1:0]  meta_q, sync_q, prev_q;
  logic [IN_CH-1:0]    flags_q, flags_d;
  logic [IN_CH-1:0]    mask_q, mask_d;
  logic [IN_CH-1:0]    evt;
  logic [OUT_CH*8-1:0] out_q, out_d;
  logic [7:0]          rd_q, rd_d;
  logic                irq_q, irq_d;
  logic                pend;
  logic                stat_clr;

  assign in_port  = rd_q;
  assign gpio_out = out_q;
  assign interrupt = irq_q;

  assign pend     = |(flags_q & mask_q);
  assign stat_clr = read_strobe && (port_id == STAT_ADDR);

  // A channel raises its flag when any of its 8 bits changed.
  always_comb begin
    evt = '0;
    for (int i = 0; i < IN_CH; i++) begin
      evt[i] = (sync_q[8*i +: 8] != prev_q[8*i +: 8]);
    end
  end

  // A new event in the clearing cycle survives the clear.
  always_comb begin
    flags_d = (stat_clr ? '0 : flags_q) | evt;
  end

  always_comb begin
    mask_d = mask_q;
    if (write_strobe && (port_id == MASK_ADDR)) begin
      mask_d = out_port[IN_CH-1:0];
    end
  end

  always_comb begin
    out_d = out_q;
    for (int j = 0; j < OUT_CH; j++) begin
      logic [7:0] a;
      a = OUT_BASE + 8'(j);
      if ((write_strobe && (port_id == a)) ||
          (k_write_strobe && (port_id[3:0] == a[3:0]))) begin
        out_d[8*j +: 8] = out_port;
      end
    end
  end

  always_comb begin
    rd_d = 8'h00;
    for (int i = 0; i < IN_CH; i++) begin
      if (port_id == IN_BASE + 8'(i)) begin
        rd_d = sync_q[8*i +: 8];
      end
    end
`ifdef IO_READBACK_EN
    for (int j = 0; j < OUT_CH; j++) begin
      if (port_id == OUT_BASE + 8'(j)) begin
        rd_d = out_q[8*j +: 8];
      end
    end
`endif
    if (port_id == STAT_ADDR) begin
      rd_d = 8'h00;
      rd_d[IN_CH-1:0] = flags_q;
    end
    if (port_id == MASK_ADDR) begin
      rd_d = 8'h00;
      rd_d[IN_CH-1:0] = mask_q;
    end
  end

  // Once requested, the interrupt is held until acked even if the
  // mask drops; WAIT blocks re-requests until the flags are cleared.
  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    unique case (state_q)
      IDLE:    if (pend) state_d = REQ;
      REQ:     if (interrupt_ack) state_d = WAIT;
      WAIT:    if (!pend) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == REQ);
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      meta_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      flags_q <= '0;
      mask_q  <= '0;
      out_q   <= '0;
      rd_q    <= '0;
      irq_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      meta_q  <= gpio_in;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      rd_q    <= rd_d;
      irq_q   <= irq_d;
      state_q <= state_d;
    end
  end

endmodule
